instr_decoder: RTL and testbench

//  Byte-stream receiver on the decoder side of the fetch->decoder link.
//  - Accepts opcode/operand bytes via the start/ready handshake and assembles

---
 rtl/instr_pkg.sv | 24 ++
 rtl/sat_counter.sv | 22 ++
 rtl/instr_decoder.sv | 121 ++++++++++++
 tb/tb_instr_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared types for the fetch->decoder byte link: FSM states, error codes,
// and where the operand count lives inside the opcode byte.
// Imported by the decoder top; no logic of its own.
package instr_pkg;

  // Decoder FSM states; encodings are fixed so they stay stable in waveforms
  typedef enum logic [1:0] {
    S_OPCODE  = 2'd0,
    S_OPERAND = 2'd1,
    S_ISSUE   = 2'd2
  } state_t;

  // Sticky error code reported alongside err_pulse
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  // The operand count occupies the top CNT_W bits of the opcode byte
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_ILLEGAL = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc strobes, sticks at all-ones.
// Latency: count reflects an inc on the following edge.
// No backpressure; inc is sampled every cycle.
module sat_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Increment on each strobe unless already saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {width{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// Assembles opcode + 0..2 operand bytes from fetch and presents them to execute.
// Latency: instr_valid rises the cycle after the last byte of an instruction transfers.
// Backpressure: ready drops while an instruction waits for ack (one lost cycle per instr).
module instr_decoder
  import instr_pkg::*;
#(
  parameter int byte_w    = 8,
  parameter int op_width  = byte_w - 2,
  parameter int timeout   = 16,
  parameter int err_cnt_w = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_for_decoder,
  input  logic [byte_w-1:0]    data_for_decoder,
  output logic                 ready_from_decoder,
  output logic                 instr_valid,
  input  logic                 instr_ack,
  output logic [op_width-1:0]  instr_op,
  output logic [2*byte_w-1:0]  instr_operand,
  output logic [1:0]           instr_nbytes,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [err_cnt_w-1:0] err_count
);

  localparam int IDLE_W = $clog2(timeout + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(timeout - 1);

  state_t            state;
  logic [IDLE_W-1:0] idle;
  logic              idx;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_in;
  logic              err_event;
  err_t              err_next;

  // Moore handshake outputs straight from the state register
  assign ready_from_decoder = (state != S_ISSUE);
  assign instr_valid        = (state == S_ISSUE);
  assign xfer               = start_for_decoder && ready_from_decoder;
  assign cnt_in             = data_for_decoder[byte_w-1 -: CNT_W];

  // Detect this cycle's error: illegal operand count, or operand gap too long
  always_comb begin
    err_event = 1'b0;
    err_next  = ERR_NONE;
    if (state == S_OPCODE && xfer && cnt_in == CNT_ILLEGAL) begin
      err_event = 1'b1;
      err_next  = ERR_ILLEGAL;
    end else if (state == S_OPERAND && !xfer && idle == IDLE_LAST) begin
      err_event = 1'b1;
      err_next  = ERR_TIMEOUT;
    end
  end

  // Main FSM: byte assembly, timeout tracking, and registered error reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_OPCODE;
      idle          <= '0;
      idx           <= 1'b0;
      instr_op      <= '0;
      instr_operand <= '0;
      instr_nbytes  <= '0;
      err_pulse     <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      err_pulse <= err_event;
      if (err_event) begin
        err_code <= err_next;
      end
      case (state)
        S_OPCODE: begin
          if (xfer) begin
            // Clear operands on every accept so stale bytes never leak
            instr_operand <= '0;
            idle          <= '0;
            idx           <= 1'b0;
            if (cnt_in != CNT_ILLEGAL) begin
              instr_op     <= data_for_decoder[op_width-1:0];
              instr_nbytes <= cnt_in;
              state        <= (cnt_in == 2'd0) ? S_ISSUE : S_OPERAND;
            end
          end
        end
        S_OPERAND: begin
          if (xfer) begin
            instr_operand[idx*byte_w +: byte_w] <= data_for_decoder;
            idle <= '0;
            idx  <= ~idx;
            if (({1'b0, idx} + 2'd1) == instr_nbytes) begin
              state <= S_ISSUE;
            end
          end else if (idle == IDLE_LAST) begin
            // Abort: drop the partial instruction and resync on an opcode
            instr_operand <= '0;
            idle          <= '0;
            state         <= S_OPCODE;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        S_ISSUE: begin
          if (instr_ack) begin
            state <= S_OPCODE;
          end
        end
        default: state <= S_OPCODE;
      endcase
    end
  end

  sat_counter #(.width(err_cnt_w)) u_err_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (err_event),
    .count (err_count)
  );

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: table of decoded instructions plus
// hand-written sequences for reset, stalls, illegal opcodes, timeout, saturation.
module tb_instr_decoder;

  localparam int BW  = 8;
  localparam int OPW = 6;
  localparam int TO  = 16;
  localparam int ECW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_for_decoder;
  logic [BW-1:0]   data_for_decoder;
  logic            ready_from_decoder;
  logic            instr_valid;
  logic            instr_ack;
  logic [OPW-1:0]  instr_op;
  logic [2*BW-1:0] instr_operand;
  logic [1:0]      instr_nbytes;
  logic            err_pulse;
  logic [1:0]      err_code;
  logic [ECW-1:0]  err_count;

  int tests = 0;
  int fails = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  instr_decoder #(
    .byte_w(BW), .op_width(OPW), .timeout(TO), .err_cnt_w(ECW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start_for_decoder  (start_for_decoder),
    .data_for_decoder   (data_for_decoder),
    .ready_from_decoder (ready_from_decoder),
    .instr_valid        (instr_valid),
    .instr_ack          (instr_ack),
    .instr_op           (instr_op),
    .instr_operand      (instr_operand),
    .instr_nbytes       (instr_nbytes),
    .err_pulse          (err_pulse),
    .err_code           (err_code),
    .err_count          (err_count)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          n;
    logic [5:0]  op;
    logic [15:0] operand;
    logic [1:0]  nb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, wait (bounded) for ready, transfer on the next edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    start_for_decoder = 1'b1;
    data_for_decoder  = b;
    while (!ready_from_decoder && n < 20) begin
      step();
      n++;
    end
    if (!ready_from_decoder) check("send_ready_timeout", 32'(ready_from_decoder), 32'd1);
    step();
    start_for_decoder = 1'b0;
  endtask

  task automatic do_ack();
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    check("ack_valid_low", 32'(instr_valid), 32'd0);
    check("ack_ready_high", 32'(ready_from_decoder), 32'd1);
  endtask

  task automatic check_err(input string name, input logic [1:0] code);
    exp_errs = (exp_errs == 3) ? 3 : exp_errs + 1;
    check({name, "_pulse"}, 32'(err_pulse), 32'd1);
    check({name, "_code"}, 32'(err_code), 32'(code));
    check({name, "_count"}, 32'(err_count), 32'(exp_errs));
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h00, 8'h00, 0, 6'h05, 16'h0000, 2'd0};
    vecs[1] = '{8'h41, 8'hAA, 8'h00, 1, 6'h01, 16'h00AA, 2'd1};
    vecs[2] = '{8'h7F, 8'h3C, 8'h00, 1, 6'h3F, 16'h003C, 2'd1};
    vecs[3] = '{8'h80, 8'hFF, 8'hEE, 2, 6'h00, 16'hEEFF, 2'd2};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 0, 6'h00, 16'h0000, 2'd0};
    vecs[5] = '{8'hBE, 8'h01, 8'h80, 2, 6'h3E, 16'h8001, 2'd2};
    vecs[6] = '{8'h42, 8'h99, 8'h00, 1, 6'h02, 16'h0099, 2'd1};

    reset = 1'b1;
    start_for_decoder = 1'b0;
    data_for_decoder = '0;
    instr_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_ready", 32'(ready_from_decoder), 32'd1);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_op", 32'(instr_op), 32'd0);
    check("rst_operand", 32'(instr_operand), 32'd0);
    check("rst_nbytes", 32'(instr_nbytes), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // Zero-operand: valid one cycle after the opcode edge, ready low until ack
    check("zo_pre_valid", 32'(instr_valid), 32'd0);
    send_byte(8'h05);
    check("zo_valid", 32'(instr_valid), 32'd1);
    check("zo_op", 32'(instr_op), 32'h05);
    check("zo_operand", 32'(instr_operand), 32'h0);
    check("zo_nbytes", 32'(instr_nbytes), 32'd0);
    step();
    check("zo_ready_low", 32'(ready_from_decoder), 32'd0);
    check("zo_valid_hold", 32'(instr_valid), 32'd1);
    do_ack();

    // Two-operand with idle gaps; an ack outside S_ISSUE must be ignored
    send_byte(8'h8A);
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    step();
    step();
    check("to_gap_valid", 32'(instr_valid), 32'd0);
    check("to_gap_ready", 32'(ready_from_decoder), 32'd1);
    send_byte(8'h34);
    step(); step(); step();
    check("to_gap2_valid", 32'(instr_valid), 32'd0);
    send_byte(8'h12);
    check("to_valid", 32'(instr_valid), 32'd1);
    check("to_op", 32'(instr_op), 32'h0A);
    check("to_operand", 32'(instr_operand), 32'h1234);
    check("to_nbytes", 32'(instr_nbytes), 32'd2);
    // Stall: ack low 5 cycles while fetch pushes an illegal byte
    start_for_decoder = 1'b1;
    data_for_decoder = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_operand", 32'(instr_operand), 32'h1234);
      check("stall_op", 32'(instr_op), 32'h0A);
      check("stall_err", 32'(err_pulse), 32'd0);
    end
    start_for_decoder = 1'b0;
    do_ack();
    check("stall_err_count", 32'(err_count), 32'd0);

    // Illegal opcode
    send_byte(8'hC1);
    check_err("ill", 2'd1);
    check("ill_valid", 32'(instr_valid), 32'd0);
    check("ill_ready", 32'(ready_from_decoder), 32'd1);
    step();
    check("ill_pulse_one", 32'(err_pulse), 32'd0);
    check("ill_code_held", 32'(err_code), 32'd1);

    // Table: decode each vector back-to-back
    for (int v = 0; v < 7; v++) begin
      send_byte(vecs[v].b0);
      if (vecs[v].n > 0) send_byte(vecs[v].b1);
      if (vecs[v].n > 1) send_byte(vecs[v].b2);
      check($sformatf("vec%0d_valid", v), 32'(instr_valid), 32'd1);
      check($sformatf("vec%0d_op", v), 32'(instr_op), 32'(vecs[v].op));
      check($sformatf("vec%0d_operand", v), 32'(instr_operand), 32'(vecs[v].operand));
      check($sformatf("vec%0d_nbytes", v), 32'(instr_nbytes), 32'(vecs[v].nb));
      do_ack();
    end

    // Timeout: 16 idle cycles after a partial operand aborts
    send_byte(8'h81);
    send_byte(8'h55);
    for (int i = 0; i < TO - 1; i++) step();
    check("to_early_pulse", 32'(err_pulse), 32'd0);
    check("to_early_code", 32'(err_code), 32'd1);
    step();
    check_err("tmo", 2'd2);
    check("tmo_valid", 32'(instr_valid), 32'd0);
    step();
    check("tmo_pulse_one", 32'(err_pulse), 32'd0);
    send_byte(8'h01);
    check("tmo_next_valid", 32'(instr_valid), 32'd1);
    check("tmo_next_op", 32'(instr_op), 32'h01);
    check("tmo_next_operand", 32'(instr_operand), 32'h0);
    do_ack();

    // Saturation: five more illegal opcodes back-to-back
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hC1);
      check_err("sat", 2'd1);
    end
    step();
    check("sat_final", 32'(err_count), 32'd3);

    // Reset mid-operand discards everything
    send_byte(8'h81);
    send_byte(8'h11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mid_rst_ready", 32'(ready_from_decoder), 32'd1);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_count", 32'(err_count), 32'd0);
    check("mid_rst_operand", 32'(instr_operand), 32'd0);
    check("mid_rst_code", 32'(err_code), 32'd0);
    send_byte(8'h03);
    check("post_rst_op", 32'(instr_op), 32'h03);
    check("post_rst_valid", 32'(instr_valid), 32'd1);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
